truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture engine for the other end of the 4-input, 1-output combinational logic blocks in this design.
- Drives the inputs A, B, C and D through all 16 combinations and samples the block's output Y for each one.
- Assembles a 16-bit truth-table signature and compares it against an expected table.
- Sits beside the unit under test on the lab board / bench; start and result pins connect to switches and LEDs.

Parameters:
- SETTLE_CYCLES, 2: number of clocks each vector is held before Y is sampled; legal range 1..15.
- EXPECTED, 16'hF888: expected truth table, where bit i is the value of Y for {A,B,C,D} = i. The default is the table of (A&B)|(C&D).

Ports:
- clk  in  1  system clock; all flops are rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level or pulse; a sweep is launched when start=1 is sampled in IDLE or DONE.
- Y  in  1  output of the unit under test (combinational from A..D).
- A  out  1  stimulus MSB (vector bit 3).
- B  out  1  stimulus (vector bit 2).
- C  out  1  stimulus (vector bit 1).
- D  out  1  stimulus LSB (vector bit 0).
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- table_out  out  16  captured truth table; bit i is Y sampled at vector i.
- pass  out  1  1 when table_out == EXPECTED; valid from the done pulse until the next start.
- mismatch_cnt  out  5  number of bits in which table_out differs from EXPECTED (0..16).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; A=B=C=D=0; busy=0; done=0; table_out=0; pass=0; mismatch_cnt=0; vector index=0; settle counter=0.
- Outputs A..D are registered and always equal the current vector index {A,B,C,D}.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1: clear table_out and mismatch_cnt, clear pass, set index=0, load settle counter=1, set busy=1, go to SETTLE.
  - Otherwise hold.
- SETTLE:
  - The vector is on A..D.
  - When the counter reaches SETTLE_CYCLES, go to SAMPLE on the next edge; otherwise increment the counter.
- SAMPLE (one cycle):
  - table_out[index] <= Y.
  - If Y != EXPECTED[index], increment mismatch_cnt.
  - If index == 15: go to DONE.
  - Otherwise: index <= index+1 (A..D update on the same edge), counter <= 1, go to SETTLE.
- Per-vector latency is SETTLE_CYCLES+1 clocks. A full sweep is 16*(SETTLE_CYCLES+1) clocks from the start edge to the done pulse; the default is 48 clocks.
- DONE entry edge:
  - done=1 for exactly one cycle.
  - busy=0.
  - pass <= (final mismatch_cnt == 0).
- DONE state:
  - table_out, pass and mismatch_cnt hold their values.
  - A..D hold 4'b1111.
  - start=1 in DONE behaves exactly as start in IDLE, including the clearing of results; otherwise stay in DONE.
- start while busy=1 is ignored; the sweep is not restarted.
- The index does not wrap; the sweep ends at 15.
- mismatch_cnt saturation: not needed; the maximum of 16 fits in 5 bits.
- start held high continuously: a new sweep begins on the cycle after each done pulse (back-to-back sweeps).
- rst_n asserted mid-sweep: immediate return to the reset values; no done pulse.
- Y is sampled synchronously with no synchronizer. The unit under test is assumed combinational from the registered A..D.

Optional Feature:
- Macro: SWEEPER_FIRST_FAIL_EN.
- When defined:
  - Adds output first_fail_idx (out, 4) and first_fail_vld (out, 1).
  - On the first SAMPLE where Y != EXPECTED[index], capture the index and set first_fail_vld=1.
  - Both are cleared at start and by reset, and held through DONE.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then start with Y driven by the model (A&B)|(C&D), SETTLE_CYCLES=2 -> done pulse exactly 48 clocks after the start edge; table_out=16'hF888; pass=1; mismatch_cnt=0.
- Y tied to 0 -> table_out=16'h0000; mismatch_cnt=7; pass=0. With SWEEPER_FIRST_FAIL_EN defined: first_fail_idx=3, first_fail_vld=1.
- Y driven by (A&B)&(C&D) -> table_out=16'h8000; mismatch_cnt=6; pass=0.
- Pulse start again at the 20th clock of a sweep -> ignored; done still arrives at clock 48, exactly one pulse.
- Assert rst_n=0 at the 30th clock of a sweep -> all outputs 0 immediately; no done; a subsequent start gives a correct full sweep.
- Hold start=1 continuously with SETTLE_CYCLES=1 -> done pulses every 33 clocks (32-clock sweep plus 1 DONE cycle); table_out is re-cleared at each restart; A..D step through 0..15 once per sweep.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input combinational block through all 16 vectors and scores its truth table.
// Optional first-failure capture is enabled by defining SWEEPER_FIRST_FAIL_EN.
module truth_table_sweeper #(
    parameter int unsigned  SETTLE_CYCLES = 2,
    parameter logic [15:0]  EXPECTED      = 16'hF888
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        Y,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [4:0]  mismatch_cnt
`ifdef SWEEPER_FIRST_FAIL_EN
    ,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_vld
`endif
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // SETTLE | vector on A..D, waiting for the UUT output to settle
    // SAMPLE | capture Y for the current vector
    // DONE   | results valid, A..D parked at 4'b1111
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_TC = SETTLE_CYCLES[3:0];

    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       miss;
    logic [4:0] mismatch_next;

    assign miss          = (Y != EXPECTED[idx]);
    assign mismatch_next = mismatch_cnt + {4'b0000, miss};

    // The vector index register drives the stimulus pins directly
    assign {A, B, C, D} = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= 4'd0;
            cnt          <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= 16'h0000;
            pass         <= 1'b0;
            mismatch_cnt <= 5'd0;
`ifdef SWEEPER_FIRST_FAIL_EN
            first_fail_idx <= 4'd0;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= SETTLE;
                        idx          <= 4'd0;
                        cnt          <= 4'd1;
                        busy         <= 1'b1;
                        table_out    <= 16'h0000;
                        pass         <= 1'b0;
                        mismatch_cnt <= 5'd0;
`ifdef SWEEPER_FIRST_FAIL_EN
                        first_fail_idx <= 4'd0;
                        first_fail_vld <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_TC) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    table_out[idx] <= Y;
                    mismatch_cnt   <= mismatch_next;
`ifdef SWEEPER_FIRST_FAIL_EN
                    if (miss && !first_fail_vld) begin
                        first_fail_idx <= idx;
                        first_fail_vld <= 1'b1;
                    end
`endif
                    if (idx == 4'd15) begin
                        // pass must reflect the count including this final sample
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (mismatch_next == 5'd0);
                    end else begin
                        idx   <= idx + 4'd1;
                        cnt   <= 4'd1;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: two sweepers (settle 2 and settle 1) checked every cycle
// against an arithmetic model of sweep progress, plus literal checks of the key scenarios.
module tb_truth_table_sweeper;

    localparam logic [15:0] EXP = 16'hF888;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [15:0] ytab [2];
    logic [1:0]  y;
    logic [1:0]  a, b, c, d, busy, done, pass;
    logic [15:0] tbl [2];
    logic [4:0]  mm [2];
`ifdef SWEEPER_FIRST_FAIL_EN
    logic [3:0]  ffi [2];
    logic [1:0]  ffv;
`endif

    int compared = 0;
    int mismatched = 0;

    // model: ms 0=idle(never started) 1=sweeping 2=done; mk = edges since start edge
    int          ms [2];
    int          mk [2];
    logic [15:0] mt [2];

    always #5 clk = ~clk;

    assign y[0] = ytab[0][{a[0], b[0], c[0], d[0]}];
    assign y[1] = ytab[1][{a[1], b[1], c[1], d[1]}];

    truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(EXP)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .Y(y[0]),
        .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]),
        .busy(busy[0]), .done(done[0]), .table_out(tbl[0]), .pass(pass[0]),
        .mismatch_cnt(mm[0])
`ifdef SWEEPER_FIRST_FAIL_EN
        , .first_fail_idx(ffi[0]), .first_fail_vld(ffv[0])
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .Y(y[1]),
        .A(a[1]), .B(b[1]), .C(c[1]), .D(d[1]),
        .busy(busy[1]), .done(done[1]), .table_out(tbl[1]), .pass(pass[1]),
        .mismatch_cnt(mm[1])
`ifdef SWEEPER_FIRST_FAIL_EN
        , .first_fail_idx(ffi[1]), .first_fail_vld(ffv[1])
`endif
    );

    function automatic int per_vec(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        if (!rst_n) begin
            ms[k] = 0; mk[k] = 0; mt[k] = 16'h0000;
        end else if (ms[k] != 1 && start[k]) begin
            ms[k] = 1; mk[k] = 0; mt[k] = ytab[k];
        end else if (ms[k] != 0) begin
            mk[k]++;
            if (ms[k] == 1 && mk[k] == 16 * per_vec(k)) ms[k] = 2;
        end
    endtask

    task automatic model_check(input int k);
        int          p;
        int          n;
        int          vi;
        logic [15:0] mask;
        logic [15:0] diff;
        logic        eb, ed, ep;
        p = per_vec(k);
        if (ms[k] == 0) begin
            n = 0; vi = 0; eb = 1'b0; ed = 1'b0;
        end else if (ms[k] == 1) begin
            n = mk[k] / p; vi = mk[k] / p; eb = 1'b1; ed = 1'b0;
        end else begin
            n = 16; vi = 15; eb = 1'b0; ed = (mk[k] == 16 * p);
        end
        mask = (n == 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
        diff = (mt[k] ^ EXP) & mask;
        ep   = (ms[k] == 2) && (diff == 16'h0000);
        check($sformatf("vec%0d", k), 32'({a[k], b[k], c[k], d[k]}), 32'(vi));
        check($sformatf("busy%0d", k), 32'(busy[k]), 32'(eb));
        check($sformatf("done%0d", k), 32'(done[k]), 32'(ed));
        check($sformatf("table%0d", k), 32'(tbl[k]), 32'(mt[k] & mask));
        check($sformatf("mism%0d", k), 32'(mm[k]), 32'($countones(diff)));
        check($sformatf("pass%0d", k), 32'(pass[k]), 32'(ep));
`ifdef SWEEPER_FIRST_FAIL_EN
        begin
            int fi;
            fi = 0;
            for (int i = 15; i >= 0; i--) if (diff[i]) fi = i;
            check($sformatf("ffvld%0d", k), 32'(ffv[k]), 32'(diff != 16'h0000));
            check($sformatf("ffidx%0d", k), 32'(ffi[k]), 32'(fi));
        end
`endif
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        if (rst_n) begin
            model_check(0);
            model_check(1);
        end
    end

    // One sweep on the settle-2 sweeper; optional stray start and mid-sweep reset.
    task automatic run0(input logic [15:0] tab, input int extra_at, input int rst_at,
                        output int done_edge, output int done_cnt);
        @(negedge clk);
        ytab[0]  = tab;
        start[0] = 1'b1;
        done_edge = -1;
        done_cnt  = 0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            #2;
            start[0] = (e + 1 == extra_at);
            if (done[0]) begin
                if (done_edge < 0) done_edge = e;
                done_cnt++;
            end
            if (e + 1 == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy[0]), 32'd0);
                check("rst_done", 32'(done[0]), 32'd0);
                check("rst_table", 32'(tbl[0]), 32'd0);
                check("rst_mism", 32'(mm[0]), 32'd0);
                check("rst_pass", 32'(pass[0]), 32'd0);
                check("rst_vec", 32'({a[0], b[0], c[0], d[0]}), 32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (5) begin
                    @(posedge clk);
                    #2;
                    if (done[0]) done_cnt++;
                end
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t_or, t_and, r;
        int de, dc, extra, prev, pulses, gap_bad;
        ytab[0] = 16'h0000;
        ytab[1] = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            t_or[i]  = (v[3] & v[2]) | (v[1] & v[0]);
            t_and[i] = (v[3] & v[2]) & (v[1] & v[0]);
        end

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy[0]), 32'd0);
        check("reset_table", 32'(tbl[0]), 32'd0);
        check("reset_vec", 32'({a[1], b[1], c[1], d[1]}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run0(t_or, 0, 0, de, dc);
        check("or_done_edge", 32'(de), 32'd48);
        check("or_done_cnt", 32'(dc), 32'd1);
        check("or_table", 32'(tbl[0]), 32'hF888);
        check("or_pass", 32'(pass[0]), 32'd1);
        check("or_mism", 32'(mm[0]), 32'd0);

        run0(16'h0000, 0, 0, de, dc);
        check("zero_table", 32'(tbl[0]), 32'h0000);
        check("zero_mism", 32'(mm[0]), 32'd7);
        check("zero_pass", 32'(pass[0]), 32'd0);
`ifdef SWEEPER_FIRST_FAIL_EN
        check("zero_ffidx", 32'(ffi[0]), 32'd3);
        check("zero_ffvld", 32'(ffv[0]), 32'd1);
`endif

        run0(t_and, 0, 0, de, dc);
        check("and_table", 32'(tbl[0]), 32'h8000);
        check("and_mism", 32'(mm[0]), 32'd6);
        check("and_pass", 32'(pass[0]), 32'd0);

        run0(t_or, 20, 0, de, dc);
        check("stray_done_edge", 32'(de), 32'd48);
        check("stray_done_cnt", 32'(dc), 32'd1);

        run0(16'(($urandom)), 0, 30, de, dc);
        check("rst_no_done", 32'(dc), 32'd0);
        r = 16'($urandom);
        run0(r, 0, 0, de, dc);
        check("post_rst_done_edge", 32'(de), 32'd48);
        check("post_rst_table", 32'(tbl[0]), 32'(r));
        check("post_rst_mism", 32'(mm[0]), 32'($countones(r ^ EXP)));

        for (int it = 0; it < 8; it++) begin
            r = 16'($urandom);
            if (it == 2) r = EXP;
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 47)) : 0;
            run0(r, extra, 0, de, dc);
            check("rand_done_edge", 32'(de), 32'd48);
            check("rand_done_cnt", 32'(dc), 32'd1);
        end

        // back-to-back sweeps on the settle-1 sweeper
        @(negedge clk);
        ytab[1]  = 16'($urandom);
        start[1] = 1'b1;
        prev = -1; pulses = 0; gap_bad = 0;
        for (int e = 0; e < 120; e++) begin
            @(posedge clk);
            #2;
            if (done[1]) begin
                if (prev < 0) check("b2b_first", 32'(e), 32'd32);
                else if (e - prev != 33) gap_bad++;
                prev = e;
                pulses++;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd3);
        check("b2b_gap", 32'(gap_bad), 32'd0);
        @(negedge clk);
        start[1] = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
